// File: rtl/hazard_tracker_pkg.sv
// Shared encodings and scoreboard-entry layout for the hazard tracker.
package hazard_tracker_pkg;

    // Tuse encodings; TUSE_NONE is the all-ones value at the default 2-bit width
    localparam int TUSE_D    = 0;
    localparam int TUSE_E    = 1;
    localparam int TUSE_M    = 2;
    localparam int TUSE_NONE = 3;

    localparam int FWD_RF = 0;
    localparam int STG_E  = 1;
    localparam int STG_M  = 2;
    localparam int STG_W  = 3;

    // Tracking entry, MSB first: {valid, wr, dst, tnew}. The operand fields
    // {rs, rt} are only ever read for entry 1, so they live beside it.
    localparam int OFF_TNEW = 0;

    function automatic int off_dst(int tw);
        return tw;
    endfunction

    function automatic int off_wr(int aw, int tw);
        return aw + tw;
    endfunction

    function automatic int off_valid(int aw, int tw);
        return aw + tw + 1;
    endfunction

    function automatic int trk_w(int aw, int tw);
        return aw + tw + 2;
    endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// Decode-side hazard bus. Optional MDU ports appear with HAZ_MDU_EN.
interface hazard_tracker_if #(
    parameter int REG_AW = 5,
    parameter int T_W    = 2,
    parameter int NSTG   = 3,
    parameter int FS_W   = $clog2(NSTG + 1)
);
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [T_W-1:0]    d_tuse_rs;
    logic [T_W-1:0]    d_tuse_rt;
    logic              d_wr;
    logic [REG_AW-1:0] d_dst;
    logic [T_W-1:0]    d_tnew;
`ifdef HAZ_MDU_EN
    logic              d_is_md;
    logic              md_start;
    logic              md_busy;
`endif
    logic              stall;
    logic [FS_W-1:0]   fwd_d_rs;
    logic [FS_W-1:0]   fwd_d_rt;
    logic [FS_W-1:0]   fwd_e_rs;
    logic [FS_W-1:0]   fwd_e_rt;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr, d_dst, d_tnew,
`ifdef HAZ_MDU_EN
        output d_is_md, md_start, md_busy,
`endif
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr, d_dst, d_tnew,
`ifdef HAZ_MDU_EN
        input  d_is_md, md_start, md_busy,
`endif
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
    );

endinterface

// File: rtl/hazard_tracker_match.sv
// Scans scoreboard entries youngest-first for one operand; returns stall request
// and forward select (stage number of the youngest ready match, else RF).
module hazard_match
    import hazard_tracker_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int T_W    = 2,
    parameter int FS_W   = 2,
    parameter int NENT   = 3,
    parameter int BASE   = 1
) (
    input  logic [REG_AW-1:0]            addr,
    input  logic [T_W-1:0]               tuse,
    input  logic [NENT-1:0]              valid,
    input  logic [NENT-1:0]              wr,
    input  logic [NENT-1:0][REG_AW-1:0]  dst,
    input  logic [NENT-1:0][T_W-1:0]     tnew,
    output logic                         stall_req,
    output logic [FS_W-1:0]              fwd_sel
);

    localparam logic [T_W-1:0] TUSE_OFF = '1;

    logic found;

    always_comb begin
        stall_req = 1'b0;
        fwd_sel   = FS_W'(FWD_RF);
        found     = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (tuse != TUSE_OFF && valid[i] && wr[i] && dst[i] != '0 && dst[i] == addr) begin
                if (tnew[i] > tuse) stall_req = 1'b1;
                // Only the youngest match may forward; older ones are shadowed
                if (!found && tnew[i] == '0) fwd_sel = FS_W'(BASE + i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// MIPS D-stage hazard unit: scoreboard pipeline, stall and forward selects.
// Optional macro HAZ_MDU_EN adds a stall for mult/div unit occupancy.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int T_W    = 2,
    parameter int NSTG   = 3,
    parameter int FS_W   = $clog2(NSTG + 1)
) (
    input  logic       clk,
    input  logic       reset,
    hazard_tracker_if.slave bus
);

    localparam int TRK_W     = trk_w(REG_AW, T_W);
    localparam int OFF_DST   = off_dst(T_W);
    localparam int OFF_WR    = off_wr(REG_AW, T_W);
    localparam int OFF_VALID = off_valid(REG_AW, T_W);

    logic [NSTG:1][TRK_W-1:0]  sb_trk;
    logic [REG_AW-1:0]         op_rs_p1;
    logic [REG_AW-1:0]         op_rt_p1;

    logic [NSTG:1]             sb_valid;
    logic [NSTG:1]             sb_wr;
    logic [NSTG:1][REG_AW-1:0] sb_dst;
    logic [NSTG:1][T_W-1:0]    sb_tnew;

    logic [REG_AW-1:0] op_rs_d;
    logic [REG_AW-1:0] op_rt_d;
    logic [TRK_W-1:0]  trk_d;
    logic              d_rs_stall;
    logic              d_rt_stall;
    logic              e_rs_stall_unused;
    logic              e_rt_stall_unused;
    logic              md_hold;
    logic              stall;

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    function automatic logic [TRK_W-1:0] age(input logic [TRK_W-1:0] e);
        logic [TRK_W-1:0] r;
        r = e;
        r[OFF_TNEW +: T_W] = sat_dec(e[OFF_TNEW +: T_W]);
        return r;
    endfunction

    // Unused operands enter E as $0 so the E-side search never forwards them
    assign op_rs_d = (bus.d_tuse_rs == '1) ? '0 : bus.d_rs;
    assign op_rt_d = (bus.d_tuse_rt == '1) ? '0 : bus.d_rt;
    assign trk_d   = {1'b1, bus.d_wr, bus.d_dst, bus.d_tnew};

    // D -> entry 1 (E), then entry k -> k+1 with tnew aging
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_trk   <= '0;
            op_rs_p1 <= '0;
            op_rt_p1 <= '0;
        end else begin
            if (stall) begin
                sb_trk[1] <= '0;
                op_rs_p1  <= '0;
                op_rt_p1  <= '0;
            end else begin
                sb_trk[1] <= trk_d;
                op_rs_p1  <= op_rs_d;
                op_rt_p1  <= op_rt_d;
            end
            for (int k = 2; k <= NSTG; k++) begin
                sb_trk[k] <= age(sb_trk[k-1]);
            end
        end
    end

    for (genvar k = 1; k <= NSTG; k++) begin : g_unpack
        assign sb_valid[k] = sb_trk[k][OFF_VALID];
        assign sb_wr[k]    = sb_trk[k][OFF_WR];
        assign sb_dst[k]   = sb_trk[k][OFF_DST +: REG_AW];
        assign sb_tnew[k]  = sb_trk[k][OFF_TNEW +: T_W];
    end

    hazard_match #(.REG_AW(REG_AW), .T_W(T_W), .FS_W(FS_W), .NENT(NSTG), .BASE(STG_E)) u_d_rs (
        .addr(bus.d_rs), .tuse(bus.d_tuse_rs),
        .valid(sb_valid), .wr(sb_wr), .dst(sb_dst), .tnew(sb_tnew),
        .stall_req(d_rs_stall), .fwd_sel(bus.fwd_d_rs)
    );

    hazard_match #(.REG_AW(REG_AW), .T_W(T_W), .FS_W(FS_W), .NENT(NSTG), .BASE(STG_E)) u_d_rt (
        .addr(bus.d_rt), .tuse(bus.d_tuse_rt),
        .valid(sb_valid), .wr(sb_wr), .dst(sb_dst), .tnew(sb_tnew),
        .stall_req(d_rt_stall), .fwd_sel(bus.fwd_d_rt)
    );

    hazard_match #(.REG_AW(REG_AW), .T_W(T_W), .FS_W(FS_W), .NENT(NSTG-1), .BASE(STG_M)) u_e_rs (
        .addr(op_rs_p1), .tuse(T_W'(TUSE_E)),
        .valid(sb_valid[NSTG:2]), .wr(sb_wr[NSTG:2]), .dst(sb_dst[NSTG:2]), .tnew(sb_tnew[NSTG:2]),
        .stall_req(e_rs_stall_unused), .fwd_sel(bus.fwd_e_rs)
    );

    hazard_match #(.REG_AW(REG_AW), .T_W(T_W), .FS_W(FS_W), .NENT(NSTG-1), .BASE(STG_M)) u_e_rt (
        .addr(op_rt_p1), .tuse(T_W'(TUSE_E)),
        .valid(sb_valid[NSTG:2]), .wr(sb_wr[NSTG:2]), .dst(sb_dst[NSTG:2]), .tnew(sb_tnew[NSTG:2]),
        .stall_req(e_rt_stall_unused), .fwd_sel(bus.fwd_e_rt)
    );

`ifdef HAZ_MDU_EN
    assign md_hold = bus.d_is_md & (bus.md_start | bus.md_busy);
`else
    assign md_hold = 1'b0;
`endif

    assign stall     = d_rs_stall | d_rt_stall | md_hold;
    assign bus.stall = stall;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed-vector scoreboard bench for hazard_tracker (define HAZ_MDU_EN to add MDU cases).
module tb_hazard_tracker;
    import hazard_tracker_pkg::*;

    localparam int REG_AW = 5;
    localparam int T_W    = 2;
    localparam int NSTG   = 3;
    localparam int FS_W   = $clog2(NSTG + 1);
    localparam int U      = TUSE_NONE;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_tracker_if #(.REG_AW(REG_AW), .T_W(T_W), .NSTG(NSTG), .FS_W(FS_W)) bus ();

    hazard_tracker #(.REG_AW(REG_AW), .T_W(T_W), .NSTG(NSTG), .FS_W(FS_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int rs, tu_rs, rt, tu_rt;
        bit wr;
        int dst, tnew;
        bit rst, is_md, md_start, md_busy;
        bit st;
        int fdrs, fdrt, fers, fert;
    } vec_t;

    typedef struct {
        int id;
        bit st;
        int fdrs, fdrt, fers, fert;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void add(int rs, int tu_rs, int rt, int tu_rt, bit wr, int dst, int tnew,
                                bit rst, bit st, int fdrs, int fdrt, int fers, int fert);
        vec_t v;
        v = '{rs, tu_rs, rt, tu_rt, wr, dst, tnew, rst, 1'b0, 1'b0, 1'b0, st, fdrs, fdrt, fers, fert};
        vecs.push_back(v);
    endfunction

    function automatic void add_md(bit is_md, bit start, bit busy, bit st);
        vec_t v;
        v = '{0, U, 0, U, 1'b0, 0, 0, 1'b0, is_md, start, busy, st, 0, 0, 0, 0};
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        bus.d_rs      = REG_AW'(v.rs);
        bus.d_tuse_rs = T_W'(v.tu_rs);
        bus.d_rt      = REG_AW'(v.rt);
        bus.d_tuse_rt = T_W'(v.tu_rt);
        bus.d_wr      = v.wr;
        bus.d_dst     = REG_AW'(v.dst);
        bus.d_tnew    = T_W'(v.tnew);
        reset         = v.rst;
`ifdef HAZ_MDU_EN
        bus.d_is_md   = v.is_md;
        bus.md_start  = v.md_start;
        bus.md_busy   = v.md_busy;
`endif
    endtask

    task automatic check(input int id, input string what, input logic [31:0] act, input int req);
        n_cmp++;
        if (act !== 32'(req)) begin
            n_bad++;
            $display("FAIL step %0d %s: got %0d, expected %0d", id, what, act, req);
        end
    endtask

    initial begin
        //  rs  tu  rt  tu  wr dst tn rst  st fdrs fdrt fers fert
        add( 0, U,  0, U, 0,  0, 0, 0,   0, 0, 0, 0, 0);  // reset state
        add(29, 1,  8, U, 1,  8, 2, 0,   0, 0, 0, 0, 0);  // lw $8
        add( 8, 1, 10, 1, 1,  9, 1, 0,   1, 0, 0, 0, 0);  // add uses $8: load-use stall
        add( 8, 1, 10, 1, 1,  9, 1, 0,   0, 0, 0, 0, 0);
        add( 0, U,  0, U, 0,  0, 0, 0,   0, 0, 0, 3, 0);  // add in E takes lw from W
        add( 0, U,  0, U, 0,  0, 0, 0,   0, 0, 0, 0, 0);
        add(10, 1, 11, 1, 1,  9, 1, 0,   0, 0, 0, 0, 0);  // add $9
        add( 9, 0,  0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0);  // beq $9: stall
        add( 9, 0,  0, 0, 0,  0, 0, 0,   0, 2, 0, 0, 0);  // beq takes $9 from M
        add( 3, 1,  0, U, 1,  2, 1, 0,   0, 0, 0, 3, 0);  // ori $2; beq in E sees add in W
        add( 4, 1,  0, U, 1,  2, 2, 0,   0, 0, 0, 0, 0);  // lw $2
        add( 2, 1,  2, 1, 1,  5, 1, 0,   1, 0, 0, 0, 0);  // add $5,$2,$2: waits on lw
        add( 2, 1,  2, 1, 1,  5, 1, 0,   0, 0, 0, 0, 0);  // ready ori is shadowed
        add( 0, U,  0, U, 0,  0, 0, 0,   0, 0, 0, 3, 3);  // lw forwarded from W to both
        add( 6, 1,  0, U, 1,  0, 1, 0,   0, 0, 0, 0, 0);  // writer to $0
        add( 0, 0,  5, U, 0,  0, 0, 0,   0, 0, 0, 0, 0);  // read $0, unused rt=$5
        add( 0, 1,  0, 1, 0,  0, 0, 0,   0, 0, 0, 0, 0);  // read $0 twice
        add(29, 1,  8, U, 1,  8, 2, 0,   0, 0, 0, 0, 0);  // lw $8
        add( 8, 1,  0, U, 1,  9, 1, 1,   1, 0, 0, 0, 0);  // use, reset during stall
        add( 8, 1,  0, U, 1,  9, 1, 0,   0, 0, 0, 0, 0);  // scoreboard cleared
        add( 0, U,  0, U, 0,  0, 0, 0,   0, 0, 0, 0, 0);
        add(29, 1,  7, U, 1,  7, 2, 0,   0, 0, 0, 0, 0);  // lw $7
        add( 6, 1,  7, 2, 0,  0, 0, 0,   0, 0, 0, 0, 0);  // sw $7: tuse M, no stall
        add( 0, U,  0, U, 0,  0, 0, 0,   0, 0, 0, 0, 0);  // lw in M not ready yet
        add( 0, U,  0, U, 0,  0, 0, 0,   0, 0, 0, 0, 0);
        add( 1, 1,  0, U, 1,  3, 1, 0,   0, 0, 0, 0, 0);  // add $3
        add( 0, 0,  3, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0);  // beq $0,$3: rt-only stall
        add( 0, 0,  3, 0, 0,  0, 0, 0,   0, 0, 2, 0, 0);
        add( 0, U,  0, U, 0,  0, 0, 0,   0, 0, 0, 0, 3);
`ifdef HAZ_MDU_EN
        add_md(1'b1, 1'b0, 1'b1, 1'b1);  // busy
        add_md(1'b1, 1'b0, 1'b1, 1'b1);
        add_md(1'b1, 1'b0, 1'b0, 1'b0);  // busy fell
        add_md(1'b0, 1'b0, 1'b1, 1'b0);  // not an md instruction
        add_md(1'b1, 1'b1, 1'b0, 1'b1);  // start pulse
        add_md(1'b0, 1'b0, 1'b0, 1'b0);
`endif

        begin
            vec_t idle;
            idle = '{0, U, 0, U, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
            drive(idle);
        end
        repeat (3) @(posedge clk);

        fork
            begin
                for (int i = 0; i < vecs.size(); i++) begin
                    exp_t e;
                    @(posedge clk);
                    #1;
                    drive(vecs[i]);
                    e = '{i, vecs[i].st, vecs[i].fdrs, vecs[i].fdrt, vecs[i].fers, vecs[i].fert};
                    exp_q.push_back(e);
                end
                @(posedge clk);
            end
            forever begin
                @(negedge clk);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.id, "stall",    32'(bus.stall),    int'(e.st));
                    check(e.id, "fwd_d_rs", 32'(bus.fwd_d_rs), e.fdrs);
                    check(e.id, "fwd_d_rt", 32'(bus.fwd_d_rt), e.fdrt);
                    check(e.id, "fwd_e_rs", 32'(bus.fwd_e_rs), e.fers);
                    check(e.id, "fwd_e_rt", 32'(bus.fwd_e_rt), e.fert);
                end
            end
        join_any
        disable fork;

        check(-1, "pending_expectations", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
